// File: rtl/mem_port_arbiter.sv
// Shares one backing-memory port between the fetch and data requesters, one outstanding access at a time.
// Optional: define MEM_ARB_ROUND_ROBIN_EN to alternate between contending ports instead of fixed data priority.
module mem_port_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int MAX_WAIT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ready,
  output logic [31:0]       i_rdata,
  output logic              i_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  input  logic [3:0]        d_wstrb,
  output logic              d_ready,
  output logic [31:0]       d_rdata,
  output logic              d_err,
  output logic              mem_valid,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [15:0] WAIT_LAST = 16'(MAX_WAIT - 1);

  state_t      state;
  state_t      state_next;
  logic        owner_data;
  logic        grant_data;
  logic        timeout;
  logic [15:0] wait_cnt;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_data;

  // Under contention the port that was not served last wins.
  always_comb begin
    grant_data = d_req && (!i_req || !last_data);
  end
`else
  always_comb begin
    grant_data = d_req;
  end
`endif

  always_comb begin
    state_next = state;
    timeout    = 1'b0;
    case (state)
      IDLE: begin
        if (i_req || d_req) state_next = BUS;
      end
      BUS: begin
        timeout = !mem_ack && (wait_cnt == WAIT_LAST);
        if (mem_ack || timeout) state_next = RESP;
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner_data <= 1'b0;
      wait_cnt   <= 16'd0;
      mem_valid  <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= 32'd0;
      mem_wstrb  <= 4'd0;
      i_ready    <= 1'b0;
      i_rdata    <= 32'd0;
      i_err      <= 1'b0;
      d_ready    <= 1'b0;
      d_rdata    <= 32'd0;
      d_err      <= 1'b0;
      busy       <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_data  <= 1'b0;
`endif
    end else begin
      i_ready <= 1'b0;
      d_ready <= 1'b0;
      busy    <= (state_next != IDLE);
      case (state)
        IDLE: begin
          if (i_req || d_req) begin
            owner_data <= grant_data;
            wait_cnt   <= 16'd0;
            mem_valid  <= 1'b1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_data  <= grant_data;
`endif
            if (grant_data) begin
              mem_we    <= d_we;
              mem_addr  <= d_addr;
              mem_wdata <= d_we ? d_wdata : 32'd0;
              mem_wstrb <= d_we ? d_wstrb : 4'd0;
            end else begin
              mem_we    <= 1'b0;
              mem_addr  <= i_addr;
              mem_wdata <= 32'd0;
              mem_wstrb <= 4'd0;
            end
          end
        end
        BUS: begin
          // An ack on the final wait cycle still counts as a normal completion.
          if (mem_ack || timeout) begin
            mem_valid <= 1'b0;
            if (owner_data) begin
              d_ready <= 1'b1;
              d_rdata <= (mem_ack && !mem_we) ? mem_rdata : 32'd0;
              d_err   <= !mem_ack;
            end else begin
              i_ready <= 1'b1;
              i_rdata <= mem_ack ? mem_rdata : 32'd0;
              i_err   <= !mem_ack;
            end
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: a transaction-timeline model predicts grants, bus windows and responses.
module tb_mem_port_arbiter;

  localparam int ADDR_W     = 32;
  localparam int MAX_WAIT   = 8;
  localparam int NUM_CYCLES = 4000;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              i_req = 1'b0;
  logic [ADDR_W-1:0] i_addr = '0;
  logic              i_ready;
  logic [31:0]       i_rdata;
  logic              i_err;
  logic              d_req = 1'b0;
  logic              d_we = 1'b0;
  logic [ADDR_W-1:0] d_addr = '0;
  logic [31:0]       d_wdata = '0;
  logic [3:0]        d_wstrb = '0;
  logic              d_ready;
  logic [31:0]       d_rdata;
  logic              d_err;
  logic              mem_valid;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_wstrb;
  logic              mem_ack = 1'b0;
  logic [31:0]       mem_rdata = '0;
  logic              busy;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_ready(d_ready), .d_rdata(d_rdata), .d_err(d_err),
    .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;

  // Model of the single in-flight transaction, as a timeline of cycle numbers.
  bit          act = 1'b0;
  bit          act_data;
  bit          act_we;
  logic [31:0] act_addr, act_wdata, act_rdata;
  logic [3:0]  act_wstrb;
  bit          act_err;
  int          t_grant, t_end, t_ready, t_ack;
  int          next_free = 0;
  bit          last_data = 1'b0;
  logic [31:0] exp_i_rdata = '0, exp_d_rdata = '0;
  bit          exp_i_err = 1'b0, exp_d_err = 1'b0;
  int          n_fetch = 0, n_data = 0, n_timeout = 0, n_reset = 0;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", tag, cyc, actual, expected);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, ".mem_valid"}, 64'(mem_valid), 64'd0);
    checkOutput({tag, ".mem_we"},    64'(mem_we),    64'd0);
    checkOutput({tag, ".mem_addr"},  64'(mem_addr),  64'd0);
    checkOutput({tag, ".mem_wdata"}, 64'(mem_wdata), 64'd0);
    checkOutput({tag, ".mem_wstrb"}, 64'(mem_wstrb), 64'd0);
    checkOutput({tag, ".i_ready"},   64'(i_ready),   64'd0);
    checkOutput({tag, ".i_rdata"},   64'(i_rdata),   64'd0);
    checkOutput({tag, ".i_err"},     64'(i_err),     64'd0);
    checkOutput({tag, ".d_ready"},   64'(d_ready),   64'd0);
    checkOutput({tag, ".d_rdata"},   64'(d_rdata),   64'd0);
    checkOutput({tag, ".d_err"},     64'(d_err),     64'd0);
    checkOutput({tag, ".busy"},      64'(busy),      64'd0);
  endtask

  task automatic checkCycle();
    bit in_bus, in_busy, rdy;
    in_bus  = act && (cyc > t_grant) && (cyc <= t_end);
    in_busy = act && (cyc > t_grant) && (cyc <= t_ready);
    rdy     = act && (cyc == t_ready);
    if (rdy) begin
      if (act_data) begin exp_d_rdata = act_rdata; exp_d_err = act_err; end
      else          begin exp_i_rdata = act_rdata; exp_i_err = act_err; end
    end
    checkOutput("mem_valid", 64'(mem_valid), 64'(in_bus));
    checkOutput("busy",      64'(busy),      64'(in_busy));
    checkOutput("i_ready",   64'(i_ready),   64'(rdy && !act_data));
    checkOutput("d_ready",   64'(d_ready),   64'(rdy && act_data));
    checkOutput("i_rdata",   64'(i_rdata),   64'(exp_i_rdata));
    checkOutput("i_err",     64'(i_err),     64'(exp_i_err));
    checkOutput("d_rdata",   64'(d_rdata),   64'(exp_d_rdata));
    checkOutput("d_err",     64'(d_err),     64'(exp_d_err));
    if (in_bus) begin
      checkOutput("mem_addr",  64'(mem_addr),  64'(act_addr));
      checkOutput("mem_we",    64'(mem_we),    64'(act_we));
      checkOutput("mem_wstrb", 64'(mem_wstrb), 64'(act_wstrb));
      if (act_we) checkOutput("mem_wdata", 64'(mem_wdata), 64'(act_wdata));
    end
  endtask

  task automatic newFetch();
    i_req  = 1'b1;
    i_addr = ADDR_W'($urandom()) & ~ADDR_W'(3);
  endtask

  task automatic newData();
    d_req   = 1'b1;
    d_we    = 1'($urandom_range(1, 0));
    d_addr  = ADDR_W'($urandom());
    d_wdata = $urandom();
    d_wstrb = 4'($urandom_range(15, 0));
  endtask

  // Drives requester and memory inputs for the current cycle.
  task automatic applyStimulus(input bit done_i, input bit done_d);
    if (done_i) begin
      if ($urandom_range(1, 0) == 1) newFetch();
      else i_req = 1'b0;
    end else if (!i_req && $urandom_range(99, 0) < 30) begin
      newFetch();
    end
    if (done_d) begin
      if ($urandom_range(1, 0) == 1) newData();
      else d_req = 1'b0;
    end else if (!d_req && $urandom_range(99, 0) < 30) begin
      newData();
    end
    mem_rdata = $urandom();
    if (act && cyc == t_ack) begin
      mem_ack   = 1'b1;
      act_err   = 1'b0;
      act_rdata = act_we ? 32'd0 : mem_rdata;
    end else if (act && cyc > t_grant && cyc <= t_end) begin
      mem_ack = 1'b0;
    end else begin
      mem_ack = ($urandom_range(3, 0) == 0);
    end
  endtask

  task automatic grantStep();
    bit win;
    int r, a;
    if (!act && cyc >= next_free && (i_req || d_req)) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      win = d_req && (!i_req || !last_data);
`else
      win = d_req;
`endif
      last_data = win;
      act       = 1'b1;
      act_data  = win;
      t_grant   = cyc;
      act_rdata = 32'd0;
      act_err   = 1'b1;
      if (win) begin
        n_data++;
        act_we    = d_we;
        act_addr  = d_addr;
        act_wdata = d_wdata;
        act_wstrb = d_we ? d_wstrb : 4'd0;
      end else begin
        n_fetch++;
        act_we    = 1'b0;
        act_addr  = i_addr;
        act_wdata = 32'd0;
        act_wstrb = 4'd0;
      end
      r = int'($urandom_range(99, 0));
      if (r < 25)      a = 1;
      else if (r < 35) a = MAX_WAIT;
      else if (r < 50) a = MAX_WAIT + 1;
      else             a = int'($urandom_range(MAX_WAIT, 1));
      if (a <= MAX_WAIT) begin
        t_ack = cyc + a;
        t_end = t_ack;
      end else begin
        n_timeout++;
        t_ack = -1;
        t_end = cyc + MAX_WAIT;
      end
      t_ready = t_end + 1;
    end
  endtask

  // Asynchronous reset in the middle of a bus wait, held two cycles.
  task automatic doReset();
    n_reset++;
    #2 reset = 1'b0;
    mem_ack = 1'b0;
    #1 checkAllZero("midreset");
    act         = 1'b0;
    last_data   = 1'b0;
    exp_i_rdata = '0;
    exp_d_rdata = '0;
    exp_i_err   = 1'b0;
    exp_d_err   = 1'b0;
    repeat (2) @(negedge clk);
    cyc += 2;
    checkAllZero("inreset");
    reset     = 1'b1;
    next_free = cyc;
  endtask

  initial begin
    bit done_i, done_d;
    #1 reset = 1'b0;
    #1 checkAllZero("reset");
    repeat (2) @(negedge clk);
    checkAllZero("reset_held");
    reset = 1'b1;
    cyc = 0;
    next_free = 0;
    applyStimulus(1'b0, 1'b0);
    grantStep();
    for (int it = 0; it < NUM_CYCLES; it++) begin
      @(negedge clk);
      cyc++;
      checkCycle();
      done_i = act && (cyc == t_ready) && !act_data;
      done_d = act && (cyc == t_ready) && act_data;
      if (act && cyc == t_ready) begin
        act = 1'b0;
        next_free = cyc + 1;
      end
      if (act && n_reset < 3 && it > 500 && cyc > t_grant + 1 && cyc < t_end &&
          $urandom_range(19, 0) == 0) begin
        doReset();
      end
      applyStimulus(done_i, done_d);
      grantStep();
    end
    $display("[TB] grants fetch=%0d data=%0d timeouts=%0d resets=%0d", n_fetch, n_data, n_timeout, n_reset);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
